// File: rtl/shift_reg_pkg.sv
// Shared types for shift_reg_nbit: shift modes, control FSM states and
// the per-bit next-value select used by shift_reg_cell.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    ROL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CELL_HOLD  = 2'b00,
    CELL_LOAD  = 2'b01,
    CELL_LEFT  = 2'b10,
    CELL_RIGHT = 2'b11
  } cell_sel_e;

endpackage

// File: rtl/shift_reg_cell.sv
// One register bit with a 4:1 next-value mux: hold, parallel load,
// take the lower neighbour (left shift) or the upper neighbour (right shift).
module shift_reg_cell
  import shift_reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  cell_sel_e sel,
  input  logic      load_bit,
  input  logic      left_bit,
  input  logic      right_bit,
  output logic      q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    case (sel)
      CELL_LOAD:  q_d = load_bit;
      CELL_LEFT:  q_d = left_bit;
      CELL_RIGHT: q_d = right_bit;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_nbit.sv
// WIDTH-bit parallel-load shift/rotate register with a drain counter and
// IDLE/RUN/DONE control. Optional synchronous clear via SHIFT_REG_NBIT_CLR_EN.
module shift_reg_nbit
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_REG_NBIT_CLR_EN
  input  logic             clr,
`endif
  input  logic             sel,
  input  logic [WIDTH-1:0] load,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cell_sel_e        cell_sel;
  mode_e            mode_m;
  logic             clr_i;
  logic             shift_en;
  logic [WIDTH-1:0] load_bits;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] right_nb;

`ifdef SHIFT_REG_NBIT_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  assign mode_m   = mode_e'(mode);
  assign shift_en = (state_q == RUN) && step && (mode_m != HOLD) && (cnt_q != '0);

  // Clear reuses the cells' load path with an all-zero word.
  assign load_bits = clr_i ? '0 : load;
  assign left_nb   = {Q[WIDTH-2:0], (mode_m == ROL) ? Q[WIDTH-1] : ser_in};
  assign right_nb  = {ser_in, Q[WIDTH-1:1]};

  always_comb begin
    cell_sel = CELL_HOLD;
    if (clr_i || sel) begin
      cell_sel = CELL_LOAD;
    end else if (shift_en) begin
      cell_sel = (mode_m == SHR) ? CELL_RIGHT : CELL_LEFT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sel) begin
      state_d = RUN;
      cnt_d   = CNT_W'(WIDTH);
    end else begin
      case (state_q)
        RUN: begin
          if (shift_en) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (cell_sel),
      .load_bit (load_bits[i]),
      .left_bit (left_nb[i]),
      .right_bit(right_nb[i]),
      .q        (Q[i])
    );
  end

  assign ser_out = (mode_m == SHR) ? Q[0] : Q[WIDTH-1];
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_nbit.sv
// Directed self-checking bench for shift_reg_nbit (WIDTH=8); covers the
// clr port as well when SHIFT_REG_NBIT_CLR_EN is defined.
module tb_shift_reg_nbit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
`ifdef SHIFT_REG_NBIT_CLR_EN
  logic             clr;
`endif
  logic             sel;
  logic [WIDTH-1:0] load;
  logic [1:0]       mode;
  logic             step;
  logic             ser_in;
  logic [WIDTH-1:0] Q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int check_count = 0;
  int error_count = 0;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHL  = 2'b01;
  localparam logic [1:0] M_SHR  = 2'b10;
  localparam logic [1:0] M_ROL  = 2'b11;

  shift_reg_nbit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef SHIFT_REG_NBIT_CLR_EN
    .clr    (clr),
`endif
    .sel    (sel),
    .load   (load),
    .mode   (mode),
    .step   (step),
    .ser_in (ser_in),
    .Q      (Q),
    .ser_out(ser_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] ld,
                               input logic [1:0] m, input logic st, input logic si);
    sel    = s;
    load   = ld;
    mode   = m;
    step   = st;
    ser_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseResetMidCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_Q", 32'(Q), 32'h00);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_ser_out", 32'(ser_out), 32'd0);
    #3 rst_n = 1'b1;
  endtask

  logic [7:0] shl_bits;

  initial begin
    rst_n  = 1'b0;
`ifdef SHIFT_REG_NBIT_CLR_EN
    clr    = 1'b0;
`endif
    sel    = 1'b0;
    load   = '0;
    mode   = M_HOLD;
    step   = 1'b0;
    ser_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_Q", 32'(Q), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SHL drain of A5
    applyStimulus(1'b1, 8'hA5, M_SHL, 1'b0, 1'b0);
    checkOutput("load_Q", 32'(Q), 32'hA5);
    checkOutput("load_busy", 32'(busy), 32'd1);
    shl_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sel = 1'b0; step = 1'b1; mode = M_SHL; ser_in = 1'b0;
      #1;
      checkOutput($sformatf("shl_ser_out_%0d", i), 32'(ser_out), 32'(shl_bits[7-i]));
      applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b0);
      checkOutput($sformatf("shl_done_%0d", i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
    end
    checkOutput("shl_final_Q", 32'(Q), 32'h00);
    checkOutput("shl_done_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b0);
    checkOutput("shl_done_pulse_end", 32'(done), 32'd0);
    checkOutput("shl_idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_step_ignored_Q", 32'(Q), 32'h00);

    // ROL with interleaved HOLD steps
    applyStimulus(1'b1, 8'h81, M_ROL, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, M_ROL, 1'b1, 1'b0);
    checkOutput("rol_first_Q", 32'(Q), 32'h03);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, M_HOLD, 1'b1, 1'b1);
    checkOutput("hold_Q", 32'(Q), 32'h03);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, M_ROL, 1'b1, 1'b0);
    checkOutput("rol_step7_done", 32'(done), 32'd0);
    checkOutput("rol_step7_Q", 32'(Q), 32'hC0);
    applyStimulus(1'b0, 8'h00, M_ROL, 1'b1, 1'b0);
    checkOutput("rol_final_Q", 32'(Q), 32'h81);
    checkOutput("rol_done", 32'(done), 32'd1);
    applyStimulus(1'b1, 8'h55, M_ROL, 1'b1, 1'b0);
    checkOutput("sel_in_done_Q", 32'(Q), 32'h55);
    checkOutput("sel_in_done_busy", 32'(busy), 32'd1);
    checkOutput("sel_in_done_done", 32'(done), 32'd0);

    // SHR fill
    applyStimulus(1'b1, 8'h00, M_SHR, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, M_SHR, 1'b1, 1'b1);
    checkOutput("shr_Q", 32'(Q), 32'hE0);
    checkOutput("shr_busy", 32'(busy), 32'd1);
    checkOutput("shr_done", 32'(done), 32'd0);

    // ser_out source follows mode
    applyStimulus(1'b1, 8'h01, M_SHR, 1'b0, 1'b0);
    checkOutput("ser_out_shr", 32'(ser_out), 32'd1);
    mode = M_SHL;
    #1;
    checkOutput("ser_out_shl", 32'(ser_out), 32'd0);

    // Load collides with step mid-run
    applyStimulus(1'b1, 8'hF0, M_SHL, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b0);
    checkOutput("pre_collide_Q", 32'(Q), 32'h00);
    applyStimulus(1'b1, 8'h3C, M_SHL, 1'b1, 1'b0);
    checkOutput("collide_Q", 32'(Q), 32'h3C);
    checkOutput("collide_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b1);
      checkOutput($sformatf("collide_done_%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("collide_final_Q", 32'(Q), 32'hFF);

    // Reset mid-run
    applyStimulus(1'b1, 8'hA5, M_SHL, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b0);
    checkOutput("pre_reset_Q", 32'(Q), 32'h50);
    pulseResetMidCycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b1);
      checkOutput($sformatf("post_reset_done_%0d", i), 32'(done), 32'd0);
    end
    checkOutput("post_reset_Q", 32'(Q), 32'h00);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

`ifdef SHIFT_REG_NBIT_CLR_EN
    applyStimulus(1'b1, 8'hA5, M_SHL, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b0);
    clr = 1'b1;
    applyStimulus(1'b1, 8'h77, M_SHL, 1'b1, 1'b1);
    clr = 1'b0;
    checkOutput("clr_Q", 32'(Q), 32'h00);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    checkOutput("clr_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 8'h00, M_SHL, 1'b1, 1'b1);
    checkOutput("clr_idle_Q", 32'(Q), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
